// File: rtl/icache_tag_refill.sv
// I-cache lookup/refill controller: hit check against the tag FIFO, line-fill burst on a miss,
// tag commit at the FIFO write pointer. Optional next-line prefetch: ICACHE_NEXT_PREFETCH_EN.
module icache_tag_refill #(
   parameter int DP    = 4,
   parameter int TAG_W = 20,
   parameter int BL    = 4,
   localparam int IW   = $clog2(DP),
   localparam int BW   = $clog2(BL)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             req_valid,
   input  logic [TAG_W-1:0] req_tag,
   output logic             req_ready,
   output logic [TAG_W-1:0] tag_cmp_data,
   input  logic [DP-1:0]    tag_hit,
   input  logic [DP-1:0]    tag_next_hit,
   input  logic [IW-1:0]    tag_wptr,
   output logic             tag_wr,
   output logic             tag_uwr,
   output logic [IW-1:0]    tag_uptr,
   output logic             tag_wvalid,
   output logic [TAG_W-1:0] tag_wtag,
   output logic             mem_req,
   output logic [TAG_W-1:0] mem_tag,
   input  logic             mem_ack,
   input  logic             mem_rvalid,
   input  logic             mem_rlast,
   output logic             data_wr,
   output logic [IW-1:0]    data_line,
   output logic [BW-1:0]    data_beat,
   output logic             resp_valid,
   output logic             resp_miss,
   output logic             resp_err,
   output logic [IW-1:0]    resp_index
);

   typedef enum logic [2:0] {IDLE, LOOKUP, MREQ, FILL, TAGWR} state_t;

   state_t          state_reg;
   logic [BW-1:0]   cnt_reg;
   logic [IW-1:0]   line_reg;
   logic [IW-1:0]   hit_idx;
   logic            err_reg;
   logic            flush_pend_reg;
   logic            pf_reg;
   logic            last_beat;
   logic            beat_err;

   // Highest set bit wins, matching the FIFO's own match priority.
   always_comb begin
      hit_idx = '0;
      for (int i = 0; i < DP; i++)
         if (tag_hit[i]) hit_idx = IW'(i);
   end

   assign last_beat = (cnt_reg == BW'(BL - 1));
   assign beat_err  = (mem_rlast != last_beat);
   assign req_ready = (state_reg == IDLE) && !flush;
   assign data_wr   = (state_reg == FILL) && mem_rvalid && !flush_pend_reg && !flush;
   assign data_beat = cnt_reg;
   assign data_line = line_reg;

`ifndef ICACHE_NEXT_PREFETCH_EN
   logic unused_next_hit;
   assign unused_next_hit = ^tag_next_hit;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         line_reg       <= '0;
         err_reg        <= 1'b0;
         flush_pend_reg <= 1'b0;
         pf_reg         <= 1'b0;
         tag_cmp_data   <= '0;
         tag_wr         <= 1'b0;
         tag_uwr        <= 1'b0;
         tag_uptr       <= '0;
         tag_wvalid     <= 1'b0;
         tag_wtag       <= '0;
         mem_req        <= 1'b0;
         mem_tag        <= '0;
         resp_valid     <= 1'b0;
         resp_miss      <= 1'b0;
         resp_err       <= 1'b0;
         resp_index     <= '0;
      end else begin
         tag_wr     <= 1'b0;
         tag_uwr    <= 1'b0;
         tag_wvalid <= 1'b0;
         resp_valid <= 1'b0;
         resp_miss  <= 1'b0;
         resp_err   <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req_valid && !flush) begin
                  tag_cmp_data <= req_tag;
                  state_reg    <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (flush) begin
                  state_reg <= IDLE;
               end else if (|tag_hit) begin
                  resp_valid <= 1'b1;
                  resp_index <= hit_idx;
                  state_reg  <= IDLE;
               end else begin
                  // Victim is invalidated before the burst so a flush cannot leave a stale tag.
                  line_reg       <= tag_wptr;
                  tag_uwr        <= 1'b1;
                  tag_uptr       <= tag_wptr;
                  mem_req        <= 1'b1;
                  mem_tag        <= tag_cmp_data;
                  cnt_reg        <= '0;
                  err_reg        <= 1'b0;
                  flush_pend_reg <= 1'b0;
                  pf_reg         <= 1'b0;
                  state_reg      <= MREQ;
               end
            end
            MREQ: begin
               if (flush) flush_pend_reg <= 1'b1;
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  state_reg <= FILL;
               end
            end
            FILL: begin
               if (flush) flush_pend_reg <= 1'b1;
               if (mem_rvalid) begin
                  cnt_reg <= cnt_reg + BW'(1);
                  if (beat_err) err_reg <= 1'b1;
                  if (last_beat) begin
                     tag_wr     <= !(flush_pend_reg || flush);
                     tag_wvalid <= 1'b1;
                     tag_wtag   <= tag_cmp_data;
                     resp_valid <= !pf_reg;
                     resp_miss  <= !pf_reg;
                     resp_err   <= !pf_reg && (err_reg || beat_err || flush_pend_reg || flush);
                     resp_index <= line_reg;
                     state_reg  <= TAGWR;
                  end
               end
            end
            TAGWR: begin
`ifdef ICACHE_NEXT_PREFETCH_EN
               // The current tag is committed this cycle, so the next free slot is wptr+1.
               if (!pf_reg && !flush_pend_reg && !err_reg && !flush && tag_next_hit == '0) begin
                  pf_reg       <= 1'b1;
                  tag_cmp_data <= tag_cmp_data + TAG_W'(1);
                  mem_tag      <= tag_cmp_data + TAG_W'(1);
                  mem_req      <= 1'b1;
                  tag_uwr      <= 1'b1;
                  tag_uptr     <= tag_wptr + IW'(1);
                  line_reg     <= tag_wptr + IW'(1);
                  cnt_reg      <= '0;
                  err_reg      <= 1'b0;
                  state_reg    <= MREQ;
               end else begin
                  pf_reg    <= 1'b0;
                  state_reg <= IDLE;
               end
`else
               state_reg <= IDLE;
`endif
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_tag_refill.sv
// Directed plus randomized bench for icache_tag_refill with a tag-FIFO/memory environment
// and a line-level cache reference model.
module tb_icache_tag_refill;
   localparam int DP    = 4;
   localparam int TAG_W = 20;
   localparam int BL    = 4;
   localparam int IW    = $clog2(DP);
   localparam int BW    = $clog2(BL);

   logic             clk = 1'b0;
   logic             reset, flush, req_valid, req_ready;
   logic [TAG_W-1:0] req_tag, tag_cmp_data, tag_wtag, mem_tag;
   logic [DP-1:0]    tag_hit, tag_next_hit;
   logic [IW-1:0]    tag_wptr, tag_uptr, data_line, resp_index;
   logic             tag_wr, tag_uwr, tag_wvalid, mem_req, mem_ack, mem_rvalid, mem_rlast;
   logic             data_wr, resp_valid, resp_miss, resp_err;
   logic [BW-1:0]    data_beat;

   int n_assert = 0;
   int n_fail   = 0;

   // Environment tag FIFO, updated only from what the DUT drives.
   logic [TAG_W-1:0] f_tag [DP];
   logic             f_valid [DP];
   logic [IW-1:0]    f_wptr;
   logic             p_uwr, p_uval, p_wr;
   logic [IW-1:0]    p_uptr;
   logic [TAG_W-1:0] p_utag, p_wtag;

   // Reference model: resident lines and replacement pointer.
   logic [TAG_W-1:0] m_tag [DP];
   logic             m_valid [DP];
   int               m_wptr;

   always #5 clk = ~clk;

   icache_tag_refill #(.DP(DP), .TAG_W(TAG_W), .BL(BL)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
      .tag_cmp_data(tag_cmp_data), .tag_hit(tag_hit), .tag_next_hit(tag_next_hit),
      .tag_wptr(tag_wptr), .tag_wr(tag_wr), .tag_uwr(tag_uwr), .tag_uptr(tag_uptr),
      .tag_wvalid(tag_wvalid), .tag_wtag(tag_wtag),
      .mem_req(mem_req), .mem_tag(mem_tag), .mem_ack(mem_ack),
      .mem_rvalid(mem_rvalid), .mem_rlast(mem_rlast),
      .data_wr(data_wr), .data_line(data_line), .data_beat(data_beat),
      .resp_valid(resp_valid), .resp_miss(resp_miss), .resp_err(resp_err),
      .resp_index(resp_index)
   );

   assign tag_wptr = f_wptr;

   always_comb begin
      tag_hit      = '0;
      tag_next_hit = '0;
      for (int i = 0; i < DP; i++) begin
         if (f_valid[i] && f_tag[i] == tag_cmp_data) tag_hit[i] = 1'b1;
         if (f_valid[i] && f_tag[i] == TAG_W'(tag_cmp_data + 1'b1)) tag_next_hit[i] = 1'b1;
      end
   end

   task automatic chk(input string name, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic clear_all();
      for (int i = 0; i < DP; i++) begin
         f_valid[i] = 1'b0; f_tag[i] = '0;
         m_valid[i] = 1'b0; m_tag[i] = '0;
      end
      f_wptr = '0;
      m_wptr = 0;
   endtask

   task automatic preload(input int idx, input logic [TAG_W-1:0] t);
      f_tag[idx] = t; f_valid[idx] = 1'b1;
      m_tag[idx] = t; m_valid[idx] = 1'b1;
   endtask

   // Advance one cycle; commit to the FIFO whatever the DUT drove during the previous cycle.
   task automatic step();
      @(posedge clk);
      #1;
      if (p_uwr) begin f_valid[p_uptr] = p_uval; f_tag[p_uptr] = p_utag; end
      if (p_wr) begin f_tag[f_wptr] = p_wtag; f_valid[f_wptr] = 1'b1; f_wptr = f_wptr + 1'b1; end
      if (flush) begin
         for (int i = 0; i < DP; i++) f_valid[i] = 1'b0;
         f_wptr = '0;
      end
      p_uwr = tag_uwr; p_uptr = tag_uptr; p_uval = tag_wvalid; p_utag = tag_wtag;
      p_wr = tag_wr; p_wtag = tag_wtag;
   endtask

   // rlast_at: beat carrying mem_rlast in the demand burst (-1 = never); flush_at: beat with flush (-1 = none).
   task automatic txn(input logic [TAG_W-1:0] t, input int ack_dly, input int rlast_at,
                      input int flush_at, input bit gaps);
      bit exp_hit, exp_err, exp_pf, acked, fin, exp_dw;
      int exp_idx, exp_line, exp_beats, cyc, beat, wait_cnt, n_burst, n_resp, n_wr, n_uwr;
      int n_data0, bad, resp_cyc, rdy_cyc, mreq_cyc, last_cyc, uwr_line, drv_beat, drv_burst;
      int r_miss, r_err, r_idx, uwr_v;
      logic [TAG_W-1:0] nt, b_tag0, b_tag1, wr_tag0, wr_tag1;

      // Reference outcome.
      exp_hit = 0; exp_idx = 0; exp_pf = 0; nt = t + 1'b1;
      for (int i = 0; i < DP; i++)
         if (m_valid[i] && m_tag[i] == t) begin exp_hit = 1; exp_idx = i; end
      exp_line  = m_wptr;
      exp_beats = (flush_at >= 0) ? flush_at : BL;
      exp_err   = (rlast_at != BL - 1) || (flush_at >= 0);
      if (!exp_hit) begin
         m_valid[exp_line] = 1'b0;
`ifdef ICACHE_NEXT_PREFETCH_EN
         if (!exp_err) begin
            exp_pf = 1;
            for (int i = 0; i < DP; i++)
               if (m_valid[i] && m_tag[i] == nt) exp_pf = 0;
         end
`endif
         if (flush_at >= 0) begin
            for (int i = 0; i < DP; i++) m_valid[i] = 1'b0;
            m_wptr = 0;
         end else begin
            m_tag[exp_line] = t; m_valid[exp_line] = 1'b1;
            m_wptr = (exp_line + 1) % DP;
            if (exp_pf) begin
               m_tag[m_wptr] = nt; m_valid[m_wptr] = 1'b1;
               m_wptr = (m_wptr + 1) % DP;
            end
         end
      end

      cyc = 0; beat = 0; wait_cnt = 0; n_burst = 0; n_resp = 0; n_wr = 0; n_uwr = 0;
      n_data0 = 0; bad = 0; resp_cyc = -1; rdy_cyc = -1; mreq_cyc = -1; last_cyc = -1;
      uwr_line = -1; uwr_v = -1; r_miss = -1; r_err = -1; r_idx = -1;
      drv_beat = 0; drv_burst = 0; acked = 0; fin = 0;
      b_tag0 = '0; b_tag1 = '0; wr_tag0 = '0; wr_tag1 = '0;

      step();
      req_valid = 1'b1; req_tag = t;
      #1;
      chk("req_ready_idle", int'(req_ready), 1);
      step();
      req_valid = 1'b0;

      while (!fin && cyc < 400) begin
         step();
         cyc++;
         mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; flush = 1'b0;
         if (resp_valid) begin
            n_resp++; resp_cyc = cyc;
            r_miss = int'(resp_miss); r_err = int'(resp_err); r_idx = int'(resp_index);
         end
         if (tag_uwr) begin
            n_uwr++;
            if (n_uwr == 1) begin uwr_line = int'(tag_uptr); uwr_v = int'(tag_wvalid); end
         end
         if (tag_wr) begin
            n_wr++;
            if (n_wr == 1) wr_tag0 = tag_wtag; else wr_tag1 = tag_wtag;
         end
         if (mem_req && !acked) begin
            if (wait_cnt == 0) begin
               if (n_burst == 0) begin b_tag0 = mem_tag; mreq_cyc = cyc; end
               else b_tag1 = mem_tag;
            end
            if (wait_cnt == ack_dly) begin mem_ack = 1'b1; acked = 1; end
            else wait_cnt++;
         end else if (acked && (!gaps || $urandom_range(0, 2) != 0)) begin
            mem_rvalid = 1'b1;
            drv_beat   = beat;
            drv_burst  = n_burst;
            mem_rlast  = (n_burst == 0) ? (beat == rlast_at) : (beat == BL - 1);
            if (n_burst == 0 && beat == flush_at) flush = 1'b1;
            if (beat == BL - 1) begin
               if (n_burst == 0) last_cyc = cyc;
               acked = 0; wait_cnt = 0; beat = 0; n_burst++;
            end else begin
               beat++;
            end
         end
         #1;
         exp_dw = mem_rvalid && !(drv_burst == 0 && flush_at >= 0 && drv_beat >= flush_at);
         if (data_wr !== exp_dw) bad++;
         else if (data_wr) begin
            if (data_beat !== BW'(drv_beat)) bad++;
            if (data_line !== ((drv_burst == 0) ? IW'(exp_line) : IW'(exp_line + 1))) bad++;
            if (drv_burst == 0) n_data0++;
         end
         if (n_resp > 0 && req_ready) begin rdy_cyc = cyc; fin = 1; end
      end
      mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; flush = 1'b0;

      chk("completed", int'(fin), 1);
      chk("resp_count", n_resp, 1);
      chk("resp_miss", r_miss, int'(!exp_hit));
      chk("resp_index", r_idx, exp_hit ? exp_idx : exp_line);
      chk("resp_err", r_err, int'(!exp_hit && exp_err));
      chk("beat_errors", bad, 0);
      if (exp_hit) begin
         chk("hit_latency", resp_cyc, 1);
         chk("hit_no_mreq", mreq_cyc, -1);
         chk("hit_no_uwr", n_uwr, 0);
         chk("hit_no_wr", n_wr, 0);
         chk("hit_ready", rdy_cyc, resp_cyc);
      end else begin
         chk("mreq_cycle", mreq_cyc, 1);
         chk("mem_tag", int'(b_tag0), int'(t));
         chk("uwr_line", uwr_line, exp_line);
         chk("uwr_valid", uwr_v, 0);
         chk("uwr_count", n_uwr, exp_pf ? 2 : 1);
         chk("data_beats", n_data0, exp_beats);
         chk("miss_latency", resp_cyc, last_cyc + 1);
         chk("bursts", n_burst, exp_pf ? 2 : 1);
         chk("tag_wr_count", n_wr, ((flush_at >= 0) ? 0 : 1) + (exp_pf ? 1 : 0));
         if (flush_at < 0) chk("wr_tag", int'(wr_tag0), int'(t));
         if (exp_pf) begin
            chk("pf_mem_tag", int'(b_tag1), int'(nt));
            chk("pf_wr_tag", int'(wr_tag1), int'(nt));
         end else begin
            chk("ready_after_resp", rdy_cyc, resp_cyc + 1);
         end
      end
      $display("txn tag=%05h hit=%0b line=%0d err=%0b pf=%0b cycles=%0d",
               t, exp_hit, exp_hit ? exp_idx : exp_line, exp_err, exp_pf, cyc);
   endtask

   initial begin
      int ack, rl, fl;
      reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_tag = '0;
      mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0;
      p_uwr = 1'b0; p_uval = 1'b0; p_wr = 1'b0; p_uptr = '0; p_utag = '0; p_wtag = '0;
      clear_all();
      repeat (3) step();
      chk("rst_req_ready", int'(req_ready), 1);
      chk("rst_mem_req", int'(mem_req), 0);
      chk("rst_resp_valid", int'(resp_valid), 0);
      chk("rst_tag_wr", int'(tag_wr | tag_uwr), 0);
      chk("rst_data_wr", int'(data_wr), 0);
      chk("rst_cmp_data", int'(tag_cmp_data), 0);
      reset = 1'b0;
      step();

      // Basic miss into an empty FIFO, then a hit on a preloaded line.
      txn(20'h00040, 3, BL - 1, -1, 1'b0);
      preload(2, 20'h00123);
      txn(20'h00123, 0, BL - 1, -1, 1'b0);
      // Duplicate matches: highest index must be reported.
      preload(1, 20'h00555);
      preload(3, 20'h00555);
      txn(20'h00555, 0, BL - 1, -1, 1'b0);
      // Framing errors: early rlast, then missing rlast.
      txn(20'h00600, 1, 1, -1, 1'b0);
      txn(20'h00700, 0, -1, -1, 1'b1);
      // Flush during beat 2 of the burst.
      txn(20'h00800, 2, BL - 1, 2, 1'b0);

      // Flush while idle blocks acceptance and empties the cache.
      flush = 1'b1;
      #1;
      chk("flush_idle_ready", int'(req_ready), 0);
      step();
      flush = 1'b0;
      for (int i = 0; i < DP; i++) m_valid[i] = 1'b0;
      m_wptr = 0;

      // Wrap: five misses on a four-line FIFO, then the first tag is gone.
      for (int k = 0; k < 5; k++) txn(TAG_W'(20'h00200 + 16 * k), 0, BL - 1, -1, 1'b0);
      txn(20'h00200, 0, BL - 1, -1, 1'b0);

      // Randomized traffic over a small tag pool.
      for (int k = 0; k < 40; k++) begin
         ack = $urandom_range(0, 3);
         rl  = $urandom_range(0, 9);
         rl  = (rl < 7) ? BL - 1 : (rl == 7) ? -1 : int'($urandom_range(0, BL - 2));
         fl  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, BL - 1)) : -1;
         txn(TAG_W'(20'h00100 + $urandom_range(0, 7)), ack, rl, fl, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no completion, expected $finish before time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
